lcd_timing_controller: RTL

Generates the LCD dot/line/frame timebase that sequences the background, object and compositing pipelines. It owns the 4-clock dot phase, horizontal and vertical counters, blanking flags, the DISPSTAT register, interrupt pulses and DMA triggers. Its row and frame strobes drive the background row counter, the frame toggle and the affine reference-point reload.

---
 rtl/lcd_timing_controller.sv | 100 ++++++++++
 1 files changed

// File: rtl/lcd_timing_controller.sv
// LCD timing controller.
// Produces the dot/line/frame timebase from one clock: a 4-clock dot phase,
// horizontal and vertical counters, blanking decodes, and row/frame strobes.
// Also owns DISPSTAT and raises the blanking/vcount interrupt and DMA pulses.
module lcd_timing_controller #(
  parameter int HDOTS    = 308,
  parameter int VLINES   = 228,
  parameter int HVISIBLE = 240,
  parameter int VVISIBLE = 160
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] dispstat_in,
  input  logic [1:0]  dispstat_we,
  output logic [15:0] dispstat_out,
  output logic [1:0]  phase,
  output logic [8:0]  hcount,
  output logic [7:0]  vcount,
  output logic        hblank,
  output logic        vblank,
  output logic        line_start,
  output logic        frame_start,
  output logic        irq_vblank,
  output logic        irq_hblank,
  output logic        irq_vcount,
  output logic        dma_hblank,
  output logic        dma_vblank
);

  localparam logic [8:0] H_LAST = 9'(HDOTS - 1);
  localparam logic [8:0] H_VIS  = 9'(HVISIBLE);
  localparam logic [7:0] V_LAST = 8'(VLINES - 1);
  localparam logic [7:0] V_VIS  = 8'(VVISIBLE);
  localparam logic [7:0] V_BEND = 8'(VLINES - 2);

  // irq_en[0] = vblank, [1] = hblank, [2] = vcount-match enable
  logic [2:0] irq_en;
  logic [7:0] lyc;
  logic       match_q;
  logic       vmatch;
  logic       line_entry;
  logic       hblank_entry;
  logic       vblank_entry;

  // Read-only and reserved DISPSTAT bits are accepted on the bus but dropped.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{dispstat_in[7:6], dispstat_in[2:0]};

  // Dot phase, dot and line counters; {hcount, phase} behaves as one counter.
  always_ff @(posedge clock) begin
    if (rst) begin
      phase  <= 2'd0;
      hcount <= 9'd0;
      vcount <= 8'd0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        if (hcount == H_LAST) begin
          hcount <= 9'd0;
          vcount <= (vcount == V_LAST) ? 8'd0 : vcount + 8'd1;
        end else begin
          hcount <= hcount + 9'd1;
        end
      end
    end
  end

  // DISPSTAT writable fields and the previous-cycle match flag for edge detect.
  // match_q resets to 1 so the reset-time match (vcount 0 == LYC 0) is not an edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      irq_en  <= 3'd0;
      lyc     <= 8'd0;
      match_q <= 1'b1;
    end else begin
      if (dispstat_we[0]) irq_en <= dispstat_in[5:3];
      if (dispstat_we[1]) lyc    <= dispstat_in[15:8];
      match_q <= vmatch;
    end
  end

  // Blanking, strobes, event pulses and DISPSTAT readback, all from registered state.
  always_comb begin
    vmatch       = (vcount == lyc);
    hblank       = (hcount >= H_VIS);
    vblank       = (vcount >= V_VIS) && (vcount <= V_BEND);
    line_start   = (hcount == H_LAST) && (phase == 2'd3);
    frame_start  = line_start && (vcount == V_LAST);
    line_entry   = (hcount == 9'd0) && (phase == 2'd0);
    vblank_entry = line_entry && (vcount == V_VIS);
    hblank_entry = (hcount == H_VIS) && (phase == 2'd0);
    dma_vblank   = vblank_entry;
    irq_vblank   = vblank_entry && irq_en[0];
    irq_hblank   = hblank_entry && irq_en[1];
    dma_hblank   = hblank_entry && (vcount < V_VIS);
    irq_vcount   = vmatch && !match_q && irq_en[2];
    dispstat_out = {lyc, 2'b00, irq_en, vmatch, hblank, vblank};
  end

endmodule
